ex_stage: RTL and testbench

Registered execute stage of the RV32I core, sitting directly between decode and the `alu` instance. It selects ALU operands, drives the ALU, resolves branches and jumps, and presents the result in a one-entry output register with a valid/ready handshake toward memory/writeback. A taken branch or jump raises a single-cycle redirect to fetch.

---
 rtl/ex_stage.sv | 208 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- registered execute stage of the RV32I core.
//
// Sits between decode and the external alu instance. Selects the ALU
// operands, resolves branches and jumps locally, and presents the result in
// a one-entry output register with a valid/ready handshake toward
// memory/writeback. A taken, aligned branch or jump produces a single-cycle
// redirect pulse toward fetch.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   flush                 kill held entry and any same-cycle capture
//   in_valid / in_ready   handshake from decode
//   in_pc, in_rs1, in_rs2, in_imm, in_alu_op, in_src1_pc, in_src2_imm,
//   in_br_type, in_rd, in_wb_en     decoded instruction fields
//   alu_op, alu_in1, alu_in2        combinational drive to the ALU
//   alu_out                         ALU result
//   out_valid / out_ready           handshake toward memory/writeback
//   out_result, out_store_data, out_rd, out_wb_en, out_misalign
//                                   registered instruction payload
//   redirect_valid, redirect_pc     fetch redirect
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int RESET_PC_UNUSED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    input  logic [3:0]  in_alu_op,
    input  logic        in_src1_pc,
    input  logic        in_src2_imm,
    input  logic [3:0]  in_br_type,
    input  logic [4:0]  in_rd,
    input  logic        in_wb_en,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    input  logic [31:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [31:0] out_store_data,
    output logic [4:0]  out_rd,
    output logic        out_wb_en,
    output logic        out_misalign,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    // ALU op encoding shared with the alu instance.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    // Branch / jump type encoding from decode.
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;

    // The reserved parameter has no function; an empty block keeps it referenced.
    if (RESET_PC_UNUSED < 0) begin : g_reset_pc_unused
    end

    logic [31:0] in2_raw_s;
    logic        eq_s;
    logic        lt_s;
    logic        ltu_s;
    logic        taken_s;
    logic        is_jump_s;
    logic [31:0] pc_target_s;
    logic [31:0] jalr_sum_s;
    logic [31:0] target_s;
    logic        misalign_s;
    logic [31:0] result_s;
    logic        wb_en_s;
    logic        capture_s;

    logic        out_valid_r;
    logic [31:0] out_result_r;
    logic [31:0] out_store_data_r;
    logic [4:0]  out_rd_r;
    logic        out_wb_en_r;
    logic        out_misalign_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;

    // Operand select toward the ALU; shifts only see a 5-bit amount.
    always_comb begin
        alu_op    = in_alu_op;
        alu_in1   = in_src1_pc  ? in_pc  : in_rs1;
        in2_raw_s = in_src2_imm ? in_imm : in_rs2;
        case (in_alu_op)
            ALU_SLL, ALU_SRL, ALU_SRA: alu_in2 = {27'd0, in2_raw_s[4:0]};
            default:                   alu_in2 = in2_raw_s;
        endcase
    end

    // Branch resolution on the register operands, independent of the ALU.
    always_comb begin
        eq_s      = (in_rs1 == in_rs2);
        lt_s      = ($signed(in_rs1) < $signed(in_rs2));
        ltu_s     = (in_rs1 < in_rs2);
        taken_s   = 1'b0;
        is_jump_s = 1'b0;
        case (in_br_type)
            BR_NONE: taken_s = 1'b0;
            BR_BEQ:  taken_s = eq_s;
            BR_BNE:  taken_s = !eq_s;
            BR_BLT:  taken_s = lt_s;
            BR_BGE:  taken_s = !lt_s;
            BR_BLTU: taken_s = ltu_s;
            BR_BGEU: taken_s = !ltu_s;
            BR_JAL: begin
                taken_s   = 1'b1;
                is_jump_s = 1'b1;
            end
            BR_JALR: begin
                taken_s   = 1'b1;
                is_jump_s = 1'b1;
            end
            default: taken_s = 1'b0;
        endcase
    end

    // Target, result and writeback-enable computation (all adds wrap mod 2^32).
    always_comb begin
        pc_target_s = in_pc + in_imm;
        jalr_sum_s  = in_rs1 + in_imm;
        if (in_br_type == BR_JALR) begin
            target_s = jalr_sum_s & ~32'd1;
        end else begin
            target_s = pc_target_s;
        end
        misalign_s = taken_s && (target_s[1:0] != 2'b00);
        if (is_jump_s) begin
            result_s = in_pc + 32'd4;
        end else begin
            result_s = alu_out;
        end
        // A misaligned jump must not link, and x0 is never written.
        wb_en_s   = in_wb_en && (in_rd != 5'd0) && !misalign_s;
        in_ready  = !out_valid_r || out_ready;
        capture_s = in_valid && in_ready && !flush;
    end

    // Output register and redirect pulse; reset beats flush, flush beats capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r      <= 1'b0;
            out_result_r     <= 32'd0;
            out_store_data_r <= 32'd0;
            out_rd_r         <= 5'd0;
            out_wb_en_r      <= 1'b0;
            out_misalign_r   <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= 32'd0;
        end else if (flush) begin
            out_valid_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_valid_r      <= 1'b1;
            out_result_r     <= result_s;
            out_store_data_r <= in_rs2;
            out_rd_r         <= in_rd;
            out_wb_en_r      <= wb_en_s;
            out_misalign_r   <= misalign_s;
            redirect_valid_r <= taken_s && !misalign_s;
            redirect_pc_r    <= target_s;
        end else begin
            // Redirect is a pulse: never repeated while the entry stalls.
            if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
            redirect_valid_r <= 1'b0;
        end
    end

    assign out_valid      = out_valid_r;
    assign out_result     = out_result_r;
    assign out_store_data = out_store_data_r;
    assign out_rd         = out_rd_r;
    assign out_wb_en      = out_wb_en_r;
    assign out_misalign   = out_misalign_r;
    assign redirect_valid = redirect_valid_r;
    assign redirect_pc    = redirect_pc_r;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- directed self-checking bench for ex_stage.
// A small behavioural ALU closes the loop on alu_in1/alu_in2/alu_op.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_SLL = 4'd2;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [31:0] in_imm;
    logic [3:0]  in_alu_op;
    logic        in_src1_pc;
    logic        in_src2_imm;
    logic [3:0]  in_br_type;
    logic [4:0]  in_rd;
    logic        in_wb_en;
    logic [3:0]  alu_op;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_wb_en;
    logic        out_misalign;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    ex_stage #(.RESET_PC_UNUSED(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_pc          (in_pc),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_imm         (in_imm),
        .in_alu_op      (in_alu_op),
        .in_src1_pc     (in_src1_pc),
        .in_src2_imm    (in_src2_imm),
        .in_br_type     (in_br_type),
        .in_rd          (in_rd),
        .in_wb_en       (in_wb_en),
        .alu_op         (alu_op),
        .alu_in1        (alu_in1),
        .alu_in2        (alu_in2),
        .alu_out        (alu_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_wb_en      (out_wb_en),
        .out_misalign   (out_misalign),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: shifts use the full in2 value, as the real ALU does.
    always_comb begin
        case (alu_op)
            ALU_ADD: alu_out = alu_in1 + alu_in2;
            ALU_SUB: alu_out = alu_in1 - alu_in2;
            ALU_SLL: alu_out = alu_in1 << alu_in2;
            ALU_SRL: alu_out = alu_in1 >> alu_in2;
            ALU_SRA: alu_out = $unsigned($signed(alu_in1) >>> alu_in2);
            default: alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then move away from it before sampling/driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] pc, input logic [31:0] rs1,
                             input logic [31:0] rs2, input logic [31:0] imm,
                             input logic [3:0] op, input logic s1pc,
                             input logic s2imm, input logic [3:0] br,
                             input logic [4:0] rd, input logic wb);
        in_pc       = pc;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_alu_op   = op;
        in_src1_pc  = s1pc;
        in_src2_imm = s2imm;
        in_br_type  = br;
        in_rd       = rd;
        in_wb_en    = wb;
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        set_instr(32'd0, 32'd0, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // ADD 5 + 7 -> x3
        set_instr(32'h0, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b0, 4'd0, 5'd3, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("add_alu_in1", alu_in1, 32'd5);
        chk("add_alu_in2", alu_in2, 32'd7);
        tick();
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_result", out_result, 32'd12);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_wb_en", {31'd0, out_wb_en}, 32'd1);
        chk("add_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("add_store_data", out_store_data, 32'd7);

        // SLL with imm 0x21: shift amount masked to 1
        set_instr(32'h0, 32'd1, 32'hDEAD, 32'h21, ALU_SLL, 1'b0, 1'b1, 4'd0, 5'd4, 1'b1);
        #1;
        chk("sll_alu_in2", alu_in2, 32'd1);
        tick();
        chk("sll_result", out_result, 32'd2);

        // BLT taken (-1 < 1), rd = x0 so writeback suppressed
        set_instr(32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, ALU_ADD, 1'b0, 1'b0, 4'd3, 5'd0, 1'b1);
        tick();
        chk("blt_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("blt_redirect_pc", redirect_pc, 32'h120);
        chk("blt_wb_x0", {31'd0, out_wb_en}, 32'd0);

        // BLTU same operands: 0xFFFFFFFF is not below 1
        set_instr(32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, ALU_ADD, 1'b0, 1'b0, 4'd5, 5'd0, 1'b0);
        tick();
        chk("bltu_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("bltu_misalign", {31'd0, out_misalign}, 32'd0);

        // BEQ not taken
        set_instr(32'h140, 32'd3, 32'd4, 32'h8, ALU_ADD, 1'b0, 1'b0, 4'd1, 5'd0, 1'b0);
        tick();
        chk("beq_redirect", {31'd0, redirect_valid}, 32'd0);

        // JALR to 0x1003 & ~1 = 0x1002: misaligned
        set_instr(32'h200, 32'h1003, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 4'd8, 5'd1, 1'b1);
        tick();
        chk("jalr_mis_pc", redirect_pc, 32'h1002);
        chk("jalr_mis_flag", {31'd0, out_misalign}, 32'd1);
        chk("jalr_mis_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("jalr_mis_wb", {31'd0, out_wb_en}, 32'd0);

        // JALR to 0x1001 & ~1 = 0x1000: aligned
        set_instr(32'h200, 32'h1001, 32'd0, 32'd0, ALU_ADD, 1'b0, 1'b1, 4'd8, 5'd1, 1'b1);
        tick();
        chk("jalr_pc", redirect_pc, 32'h1000);
        chk("jalr_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jalr_result", out_result, 32'h204);
        chk("jalr_wb", {31'd0, out_wb_en}, 32'd1);
        chk("jalr_misalign", {31'd0, out_misalign}, 32'd0);

        // Stall: JAL captured, then out_ready low for 3 cycles
        set_instr(32'h300, 32'd0, 32'd0, 32'h40, ALU_ADD, 1'b1, 1'b1, 4'd7, 5'd2, 1'b1);
        tick();
        chk("jal_redirect", {31'd0, redirect_valid}, 32'd1);
        chk("jal_redirect_pc", redirect_pc, 32'h340);
        chk("jal_result", out_result, 32'h304);
        out_ready = 1'b0;
        set_instr(32'h304, 32'd5, 32'd7, 32'd0, ALU_ADD, 1'b0, 1'b0, 4'd0, 5'd4, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_result", out_result, 32'h304);
            chk("stall_rd", {27'd0, out_rd}, 32'd2);
            chk("stall_redirect", {31'd0, redirect_valid}, 32'd0);
            chk("stall_redirect_pc", redirect_pc, 32'h340);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_result", out_result, 32'd12);
        chk("b2b_rd", {27'd0, out_rd}, 32'd4);

        // Flush with a stalled entry and a pending instruction
        set_instr(32'h400, 32'd0, 32'd0, 32'h10, ALU_ADD, 1'b0, 1'b0, 4'd7, 5'd6, 1'b1);
        tick();
        chk("pre_flush_redirect", {31'd0, redirect_valid}, 32'd1);
        out_ready = 1'b0;
        flush     = 1'b1;
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_redirect", {31'd0, redirect_valid}, 32'd0);

        // Flush blocks a capture while the stage is ready
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("flush_block_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_block_redirect", {31'd0, redirect_valid}, 32'd0);
        flush = 1'b0;

        // Reset mid-stall drops the held entry
        out_ready = 1'b1;
        set_instr(32'h500, 32'd0, 32'd9, 32'h20, ALU_ADD, 1'b0, 1'b0, 4'd7, 5'd5, 1'b1);
        tick();
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("midrst_result", out_result, 32'd0);
        chk("midrst_store", out_store_data, 32'd0);
        chk("midrst_rd", {27'd0, out_rd}, 32'd0);
        chk("midrst_wb", {31'd0, out_wb_en}, 32'd0);
        chk("midrst_redirect_pc", redirect_pc, 32'd0);

        // Idle with nothing presented: stays empty
        out_ready = 1'b1;
        tick();
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
